// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the parametrised ALU core:
//   alu_op_e      3-bit opcode carried on req_op
//   exec_state_e  execute FSM state
//   LAT_*_DEF     default latencies (accept edge to FIFO push edge)
//   lat_of()      latency selected by opcode
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        SLL = 3'd5,
        SRL = 3'd6,
        DIV = 3'd7
    } alu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } exec_state_e;

    localparam int LAT_SIMPLE_DEF = 2;
    localparam int LAT_MUL_DEF    = 4;
    localparam int LAT_DIV_DEF    = 8;

    // Latency of an opcode. Callers with overridden latencies pass them in;
    // the defaults match the package localparams.
    function automatic int lat_of(input alu_op_e op,
                                  input int lat_simple = LAT_SIMPLE_DEF,
                                  input int lat_mul    = LAT_MUL_DEF,
                                  input int lat_div    = LAT_DIV_DEF);
        case (op)
            MUL:     return lat_mul;
            DIV:     return lat_div;
            default: return lat_simple;
        endcase
    endfunction

endpackage

// File: rtl/alu_resp_fifo.sv
// -----------------------------------------------------------------------------
// alu_resp_fifo
// Synchronous in-order FIFO holding one response word per entry.
//   clk, rst_n      clock / async active-low reset (clears pointers and count)
//   push, wdata     write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   rdata           word at the head, mem[rptr]
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module alu_resp_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; contents are only visible through a valid head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/alu_param_core.sv
// -----------------------------------------------------------------------------
// alu_param_core
// Parametrised ALU execution core with an in-order response FIFO.
//   clk, rst_n                  clock / async active-low reset
//   req_valid/req_ready         request handshake (ready is combinational)
//   req_op, req_op1, req_op2    opcode (alu_op_e) and unsigned operands
//   req_id                      tag echoed on the response
//   resp_valid/resp_ready       response handshake, pop on valid && ready
//   resp_result, resp_id        FIFO head payload
//   resp_err                    head flagged as divide-by-zero
//   resp_count                  FIFO occupancy
// The result is computed on the accept edge and held while a down-counter
// models the operation latency. A request is only accepted when the FIFO has
// a free slot and nothing is in flight, so that slot stays reserved (only
// pops can change the count meanwhile) and the push can never be refused.
// -----------------------------------------------------------------------------
module alu_param_core
    import alu_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 4,
    parameter  int ID_W       = 4,
    parameter  int LAT_SIMPLE = LAT_SIMPLE_DEF,
    parameter  int LAT_MUL    = LAT_MUL_DEF,
    parameter  int LAT_DIV    = LAT_DIV_DEF,
    localparam int RES_W      = 2 * DATA_W,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    input  logic [ID_W-1:0]   req_id,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RES_W-1:0]  resp_result,
    output logic [ID_W-1:0]   resp_id,
    output logic              resp_err,
    output logic [CW-1:0]     resp_count
);

    localparam int SH_W    = $clog2(DATA_W);
    localparam int MAX_LAT = (LAT_SIMPLE > LAT_MUL)
                           ? ((LAT_SIMPLE > LAT_DIV) ? LAT_SIMPLE : LAT_DIV)
                           : ((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef struct packed {
        logic             err;
        logic [ID_W-1:0]  id;
        logic [RES_W-1:0] result;
    } resp_t;

    localparam int PAY_W = $bits(resp_t);

    // ------------------------------------------------------------------
    // Combinational result datapath, evaluated on the request operands
    // ------------------------------------------------------------------
    alu_op_e           op;
    logic [RES_W-1:0]  op1_x;
    logic [RES_W-1:0]  op2_x;
    logic [SH_W-1:0]   sh;
    logic [DATA_W-1:0] sll_v;
    logic [RES_W-1:0]  alu_res;
    logic              alu_err;

    assign op    = alu_op_e'(req_op);
    assign op1_x = RES_W'(req_op1);
    assign op2_x = RES_W'(req_op2);
    assign sh    = req_op2[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        sll_v   = '0;
        case (op)
            ADD: alu_res = op1_x + op2_x;   // carry lands in bit DATA_W
            SUB: alu_res = op1_x - op2_x;   // wraps modulo 2^RES_W
            MUL: alu_res = op1_x * op2_x;
            AND: alu_res = op1_x & op2_x;
            XOR: alu_res = op1_x ^ op2_x;
            SLL: begin
                // Shift in operand width so bits pushed past DATA_W are dropped.
                sll_v   = req_op1 << sh;
                alu_res = RES_W'(sll_v);
            end
            SRL: alu_res = RES_W'(req_op1 >> sh);
            DIV: begin
                if (req_op2 == '0) begin
                    alu_res = '1;
                    alu_err = 1'b1;
                end else begin
                    alu_res = RES_W'(req_op1 / req_op2);
                end
            end
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Execute FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    exec_state_e      state;
    exec_state_e      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    resp_t            pay_q;
    logic             busy;
    logic             push;
    logic             accept;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [PAY_W-1:0] fifo_rdata;
    resp_t            head;

    // Counter is loaded with LAT-1 so the push lands on edge accept+LAT.
    assign cnt_load = CNT_W'(lat_of(op, LAT_SIMPLE, LAT_MUL, LAT_DIV) - 1);
    assign accept   = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            pay_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt          <= cnt_load;
                pay_q.err    <= alu_err;
                pay_q.id     <= req_id;
                pay_q.result <= alu_res;
            end else if (state == S_EXEC && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)     state_nxt = S_EXEC;
            S_EXEC:  if (cnt == '0)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_EXEC);
        push = (state == S_EXEC) && (cnt == '0);
    end

    // A free slot at accept time is still free at push time, since only
    // pops can move the count while busy.
    assign req_ready = !busy && !fifo_full;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    assign pop = resp_valid && resp_ready;

    alu_resp_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (pay_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (resp_count)
    );

    assign head        = resp_t'(fifo_rdata);
    assign resp_valid  = !fifo_empty;
    assign resp_result = head.result;
    assign resp_id     = head.id;
    assign resp_err    = head.err;

endmodule
